// File: rtl/ifu_pkg.sv
// -----------------------------------------------------------------------------
// ifu_pkg
//   Shared constants and types for the instruction fetch unit.
//   - RESET_PC_DEFAULT : PC of the first fetch after reset (text segment base)
//   - NOP              : canonical RISC-V NOP (addi x0, x0, 0)
//   - OP_I_ARITH/OP_LUI: opcode constants consumed by the immediate unit
//   - fetch_state_e    : fetch FSM encoding (IDLE = nothing outstanding)
//   - fetch_entry_t    : one fetch queue entry {pc, instr}
// -----------------------------------------------------------------------------
package ifu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [6:0]  OP_I_ARITH       = 7'h13;
  localparam logic [6:0]  OP_LUI           = 7'h37;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Word-align an address by clearing the two byte-offset bits.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit_if
//   Bus bundle of the fetch unit: the instruction-memory request channel
//   (req/addr/gnt/rvalid/rdata) and the downstream instruction stream
//   (valid/ready/instr/pc).
//   master : the fetch unit side
//   slave  : the environment side (instruction memory + decode stage)
// -----------------------------------------------------------------------------
interface instruction_fetch_unit_if;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output instr_valid_o, instr_o, instr_pc_o,
    input  instr_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  instr_valid_o, instr_o, instr_pc_o,
    output instr_ready_i
  );

endinterface

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Two-entry {pc, instr} queue between the memory response and decode.
//   Ports:
//     clk, reset   : clock, synchronous active-high reset
//     push         : write push_entry at the tail
//     pop          : drop the head entry (only when count != 0)
//     flush        : empty the queue; wins over push and pop
//     push_entry   : entry to write
//     head         : registered head entry (valid when count != 0)
//     count        : current occupancy, 0..2
//   Entry 0 is always the head; a pop shifts entry 1 down.
// -----------------------------------------------------------------------------
module fetch_fifo
  import ifu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t entry0;
  fetch_entry_t entry1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the data slots are deliberately not reset; occupancy is carried by
  // count alone, so clearing the payload would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (!flush) begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) entry0 <= push_entry;
          else               entry1 <= push_entry;
        end
        2'b01: entry0 <= entry1;
        2'b11: begin
          // With two entries the tail moves down and the new word goes
          // behind it; with one the new word replaces the head directly.
          if (count == 2'd2) begin
            entry0 <= entry1;
            entry1 <= push_entry;
          end else begin
            entry0 <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = entry0;

endmodule

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//   Fetch stage of the RISC-V core. Holds the PC, issues one word read at a
//   time to instruction memory over req/gnt/rvalid, buffers returned words
//   with their PC in a 2-entry queue and presents them under valid/ready.
//   Parameters:
//     RESET_PC : first fetch address after reset
//     DEPTH    : queue entries (only 2 supported)
//   Ports:
//     clk, reset     : clock, synchronous active-high reset
//     redirect_i     : branch/jump taken - flush and refetch from redirect_pc_i
//     redirect_pc_i  : redirect target (low two bits ignored)
//     misalign_o     : one-cycle pulse after a misaligned redirect target
//     bus (master)   : imem request channel + downstream instruction stream
//   Build option:
//     IFU_MISALIGN_CHECK_EN - when defined, misalign_o reports misaligned
//     redirect targets; otherwise it is tied low.
// -----------------------------------------------------------------------------
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      redirect_i,
  input  logic [31:0]               redirect_pc_i,
  output logic                      misalign_o,
  instruction_fetch_unit_if.master  bus
);

  localparam logic [1:0] DEPTH_W = 2'(DEPTH);

  fetch_state_e state;
  logic [31:0]  pc;        // address of the next request
  logic [31:0]  req_pc;    // address of the outstanding request
  logic         discard;   // outstanding response belongs to a flushed path

  logic         outstanding;
  logic [1:0]   used;
  logic         req;
  logic         grant;
  logic         rsp;
  logic         push;
  logic         pop;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         head_valid;

  assign outstanding = (state == WAIT);

  // Room is judged on the registered occupancy plus the outstanding request.
  // A response arriving this cycle still counts as outstanding, and a pop in
  // the same cycle does not free a slot. A new request can only start when
  // nothing is outstanding or the outstanding one completes this cycle, which
  // also holds requests back while a discarded response is pending.
  assign used  = count + {1'b0, outstanding};
  assign req   = !reset && (!outstanding || bus.imem_rvalid_i) && (used < DEPTH_W);
  assign grant = req && bus.imem_gnt_i;
  assign rsp   = outstanding && bus.imem_rvalid_i;

  // A redirect flushes the queue, so the word returning in that cycle is
  // dropped along with everything already buffered.
  assign push       = rsp && !discard && !redirect_i;
  assign pop        = bus.instr_valid_o && bus.instr_ready_i;
  assign push_entry = '{pc: req_pc, instr: bus.imem_rdata_i};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      req_pc  <= '0;
      discard <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            state  <= WAIT;
            req_pc <= pc;
            pc     <= pc + 32'd4;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid_i) begin
            discard <= 1'b0;
            if (grant) begin
              req_pc <= pc;
              pc     <= pc + 32'd4;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Redirect overrides the PC update above. Any request still in flight
      // after this edge (old one not yet answered, or one granted now) must
      // have its response thrown away.
      if (redirect_i) begin
        pc      <= align_word(redirect_pc_i);
        discard <= (outstanding && !bus.imem_rvalid_i) || grant;
      end
    end
  end

  fetch_fifo u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_i),
    .push_entry (push_entry),
    .head       (head),
    .count      (count)
  );

  assign head_valid = !reset && (count != 2'd0);

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = pc;
  assign bus.instr_valid_o = head_valid;
  assign bus.instr_o       = head_valid ? head.instr : NOP;
  assign bus.instr_pc_o    = head_valid ? head.pc    : 32'h0000_0000;

`ifdef IFU_MISALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
  end

  assign misalign_o = misalign_q && !reset;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Directed bench for instruction_fetch_unit. Inputs change 1 time unit after
//   the rising edge; outputs are checked mid-cycle. The bench plays the role
//   of instruction memory and decode, cycle by cycle.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;
  import ifu_pkg::*;

  logic        clk;
  logic        reset;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        misalign_o;

  int total;
  int bad;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .misalign_o    (misalign_o),
    .bus           (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic gnt, input logic rvalid, input logic [31:0] rdata, input logic ready);
    bus.imem_gnt_i    = gnt;
    bus.imem_rvalid_i = rvalid;
    bus.imem_rdata_i  = rdata;
    bus.instr_ready_i = ready;
  endtask

  localparam logic [31:0] W_ADDI = 32'h0050_0093;
  localparam logic [31:0] W_A    = 32'h0010_0093;
  localparam logic [31:0] W_B    = 32'h0020_0113;
  localparam logic [31:0] W_C    = 32'h0030_0193;
  localparam logic [31:0] W_D    = 32'h1234_5037;
  localparam logic [31:0] W_E    = 32'h0040_0213;
  localparam logic [31:0] W_F    = 32'h0060_0293;
  localparam logic [31:0] W_G    = 32'h0070_0313;
  localparam logic [31:0] STALE  = 32'hDEAD_BEEF;

  logic [31:0] misalign_exp;

  initial begin
    total = 0;
    bad   = 0;
`ifdef IFU_MISALIGN_CHECK_EN
    misalign_exp = 32'd1;
`else
    misalign_exp = 32'd0;
`endif

    // ---------------- reset values ----------------
    reset = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    drive(1'b1, 1'b0, '0, 1'b0);
    tick(); tick(); #3;
    chk("rst_req",      {31'd0, bus.imem_req_o},    32'd0);
    chk("rst_valid",    {31'd0, bus.instr_valid_o}, 32'd0);
    chk("rst_instr",    bus.instr_o,                NOP);
    chk("rst_pc",       bus.instr_pc_o,             32'd0);
    chk("rst_misalign", {31'd0, misalign_o},        32'd0);

    // ---------------- first fetch latency ----------------
    tick(); reset = 1'b0; drive(1'b1, 1'b0, '0, 1'b0);          // cycle 0
    #3;
    chk("c0_req",  {31'd0, bus.imem_req_o}, 32'd1);
    chk("c0_addr", bus.imem_addr_o,         32'h0040_0000);
    tick(); drive(1'b0, 1'b1, W_ADDI, 1'b0);                    // cycle 1
    #3;
    chk("c1_valid", {31'd0, bus.instr_valid_o}, 32'd0);
    tick(); drive(1'b0, 1'b0, '0, 1'b1);                        // cycle 2
    #3;
    chk("c2_valid",  {31'd0, bus.instr_valid_o}, 32'd1);
    chk("c2_pc",     bus.instr_pc_o,             32'h0040_0000);
    chk("c2_instr",  bus.instr_o,                W_ADDI);
    chk("c2_opcode", {25'd0, bus.instr_o[6:0]},  {25'd0, OP_I_ARITH});
    chk("c2_addr",   bus.imem_addr_o,            32'h0040_0004);
    tick(); drive(1'b0, 1'b0, '0, 1'b0);                        // cycle 3
    #3;
    chk("c3_popped", {31'd0, bus.instr_valid_o}, 32'd0);

    // ---------------- stall: two entries, no third request ----------------
    tick(); reset = 1'b1;
    tick(); reset = 1'b0; drive(1'b1, 1'b0, '0, 1'b0);          // s0
    #3;
    chk("s0_addr", bus.imem_addr_o, 32'h0040_0000);
    tick(); drive(1'b1, 1'b1, W_A, 1'b0);                       // s1
    #3;
    chk("s1_req",  {31'd0, bus.imem_req_o}, 32'd1);
    chk("s1_addr", bus.imem_addr_o,         32'h0040_0004);
    tick(); drive(1'b1, 1'b1, W_B, 1'b0);                       // s2
    #3;
    chk("s2_noreq",  {31'd0, bus.imem_req_o}, 32'd0);
    chk("s2_headpc", bus.instr_pc_o,          32'h0040_0000);
    tick(); drive(1'b1, 1'b0, '0, 1'b0);                        // s3
    #3;
    chk("s3_noreq", {31'd0, bus.imem_req_o}, 32'd0);
    chk("s3_head",  bus.instr_o,             W_A);
    tick(); drive(1'b1, 1'b0, '0, 1'b1);                        // s4: pop A
    #3;
    chk("s4_noreq", {31'd0, bus.imem_req_o}, 32'd0);
    chk("s4_head",  bus.instr_pc_o,          32'h0040_0000);
    tick(); drive(1'b1, 1'b0, '0, 1'b1);                        // s5: pop B, grant
    #3;
    chk("s5_headpc", bus.instr_pc_o,          32'h0040_0004);
    chk("s5_head",   bus.instr_o,             W_B);
    chk("s5_req",    {31'd0, bus.imem_req_o}, 32'd1);
    chk("s5_addr",   bus.imem_addr_o,         32'h0040_0008);
    tick(); drive(1'b0, 1'b1, W_C, 1'b1);                       // s6
    #3;
    chk("s6_empty", {31'd0, bus.instr_valid_o}, 32'd0);
    tick(); drive(1'b1, 1'b0, '0, 1'b1);                        // s7: pop C, grant 0x40000C
    #3;
    chk("s7_pc",   bus.instr_pc_o,  32'h0040_0008);
    chk("s7_addr", bus.imem_addr_o, 32'h0040_000C);

    // ---------------- redirect the cycle after a grant ----------------
    tick(); drive(1'b0, 1'b0, '0, 1'b1);                        // r0
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0100;
    #3;
    chk("r0_noreq", {31'd0, bus.imem_req_o}, 32'd0);
    tick(); redirect_i = 1'b0; drive(1'b1, 1'b1, STALE, 1'b1);  // r1: stale rvalid
    #3;
    chk("r1_valid", {31'd0, bus.instr_valid_o}, 32'd0);
    chk("r1_req",   {31'd0, bus.imem_req_o},    32'd1);
    chk("r1_addr",  bus.imem_addr_o,            32'h0040_0100);
    tick(); drive(1'b0, 1'b1, W_D, 1'b0);                       // r2
    #3;
    chk("r2_dropped", {31'd0, bus.instr_valid_o}, 32'd0);
    tick(); drive(1'b1, 1'b0, '0, 1'b0);                        // r3: grant 0x400104
    #3;
    chk("r3_valid",  {31'd0, bus.instr_valid_o}, 32'd1);
    chk("r3_pc",     bus.instr_pc_o,             32'h0040_0100);
    chk("r3_opcode", {25'd0, bus.instr_o[6:0]},  {25'd0, OP_LUI});

    // ---------------- redirect + rvalid + pop together ----------------
    tick(); drive(1'b0, 1'b1, W_E, 1'b1);                       // p0
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0200;
    #3;
    chk("p0_noreq", {31'd0, bus.imem_req_o}, 32'd0);
    tick(); redirect_i = 1'b0; drive(1'b0, 1'b0, '0, 1'b0);     // p1
    #3;
    chk("p1_empty", {31'd0, bus.instr_valid_o}, 32'd0);
    chk("p1_req",   {31'd0, bus.imem_req_o},    32'd1);
    chk("p1_addr",  bus.imem_addr_o,            32'h0040_0200);

    // ---------------- misaligned redirect target ----------------
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0302;
    tick(); redirect_i = 1'b0;                                  // m0
    #3;
    chk("m0_misalign", {31'd0, misalign_o}, misalign_exp);
    chk("m0_addr",     bus.imem_addr_o,     32'h0040_0300);
    tick(); drive(1'b1, 1'b0, '0, 1'b0);                        // m1: grant 0x400300
    #3;
    chk("m1_misalign", {31'd0, misalign_o}, 32'd0);

    // ---------------- reset mid-WAIT with one entry queued ----------------
    tick(); drive(1'b0, 1'b1, W_F, 1'b0);                       // w0
    tick(); drive(1'b1, 1'b0, '0, 1'b0);                        // w1: grant 0x400304
    #3;
    chk("w1_addr", bus.imem_addr_o, 32'h0040_0304);
    tick(); drive(1'b0, 1'b0, '0, 1'b0);                        // w2: WAIT, 1 entry
    #3;
    chk("w2_valid", {31'd0, bus.instr_valid_o}, 32'd1);
    chk("w2_instr", bus.instr_o,                W_F);
    reset = 1'b1;
    #1;
    chk("w2_rst_req", {31'd0, bus.imem_req_o}, 32'd0);
    tick(); reset = 1'b0;                                       // w3
    #3;
    chk("w3_valid", {31'd0, bus.instr_valid_o}, 32'd0);
    chk("w3_instr", bus.instr_o,                NOP);
    chk("w3_pc",    bus.instr_pc_o,             32'd0);
    chk("w3_req",   {31'd0, bus.imem_req_o},    32'd1);
    chk("w3_addr",  bus.imem_addr_o,            32'h0040_0000);

    // ---------------- PC wrap-around ----------------
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick(); redirect_i = 1'b0; drive(1'b1, 1'b0, '0, 1'b0);     // x0
    #3;
    chk("x0_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
    tick(); drive(1'b0, 1'b1, W_G, 1'b0);                       // x1
    #3;
    chk("x1_wrap", bus.imem_addr_o, 32'h0000_0000);
    tick(); drive(1'b0, 1'b0, '0, 1'b0);                        // x2
    #3;
    chk("x2_pc",    bus.instr_pc_o, 32'hFFFF_FFFC);
    chk("x2_instr", bus.instr_o,    W_G);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
